double_dabble_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It uses one shift per clock, so area is a single row of digit correctors instead of a full combinational array. Input and output use valid/ready handshakes. It sits between binary datapaths (counters, ADC results) and decimal display or text formatters. It also supports optional two's-complement input and reports the number of significant digits.

---
 rtl/double_dabble_seq.sv | 109 ++++++++++
 tb/tb_double_dabble_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_dabble_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// valid/ready handshakes on both sides, optional two's-complement input.
module double_dabble_seq #(
  parameter int  BIN_WIDTH = 16,
  parameter int  SIGNED    = 0,
  localparam int DIGITS    = ((BIN_WIDTH * 1233) >> 12) + 1,
  localparam int CW        = $clog2(DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*DIGITS-1:0]  bcd_out,
  output logic                 sign_out,
  output logic [CW-1:0]        digit_count
);
  localparam int NW = $clog2(BIN_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               r_state;
  logic [BIN_WIDTH-1:0] r_shift;
  logic [4*DIGITS-1:0]  r_bcd;
  logic [NW-1:0]        r_iter;
  logic                 r_sign;
  logic                 r_outValid;
  logic [CW-1:0]        r_digitCount;

  logic                          w_neg;
  logic [BIN_WIDTH-1:0]          w_mag;
  logic [4*DIGITS-1:0]           w_corr;
  logic [4*DIGITS+BIN_WIDTH-1:0] w_shifted;
  logic [4*DIGITS-1:0]           w_nextBcd;
  logic [BIN_WIDTH-1:0]          w_nextShift;
  logic [CW-1:0]                 w_digitCount;

  assign w_neg = (SIGNED != 0) && in_data[BIN_WIDTH-1];
  // Negating the most-negative value wraps to 2^(BIN_WIDTH-1), the correct unsigned magnitude.
  assign w_mag = w_neg ? (~in_data + BIN_WIDTH'(1)) : in_data;

  always_comb begin
    w_corr = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] > 4'd4) w_corr[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_shifted   = {w_corr, r_shift} << 1;
  assign w_nextBcd   = w_shifted[4*DIGITS+BIN_WIDTH-1:BIN_WIDTH];
  assign w_nextShift = w_shifted[BIN_WIDTH-1:0];

  always_comb begin
    w_digitCount = CW'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (w_nextBcd[4*i +: 4] != 4'd0) w_digitCount = CW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_iter       <= '0;
      r_sign       <= 1'b0;
      r_outValid   <= 1'b0;
      r_digitCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= w_mag;
            r_bcd   <= '0;
            r_iter  <= NW'(BIN_WIDTH - 1);
            r_sign  <= w_neg;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd   <= w_nextBcd;
          r_shift <= w_nextShift;
          r_iter  <= r_iter - 1'b1;
          if (r_iter == '0) begin
            r_digitCount <= w_digitCount;
            r_outValid   <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_outValid;
  assign bcd_out     = r_bcd;
  assign sign_out    = r_sign;
  assign digit_count = r_digitCount;

endmodule

// File: tb/tb_double_dabble_seq.sv
// Bench for double_dabble_seq: 16-bit unsigned/signed, 10-bit and 32-bit builds
// checked against hand-computed vectors and a divide-by-ten reference model.
module tb_double_dabble_seq;

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic [63:0] bcd;
    logic        sign;
    int          count;
  } vec_t;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        inValid;
  logic        outReady;
  logic [31:0] inData;

  logic        inReadyU16, outValidU16, signU16;
  logic [19:0] bcdU16;
  logic [2:0]  countU16;
  logic        inReadyS16, outValidS16, signS16;
  logic [19:0] bcdS16;
  logic [2:0]  countS16;
  logic        inReadyU10, outValidU10, signU10;
  logic [15:0] bcdU10;
  logic [2:0]  countU10;
  logic        inReadyU32, outValidU32, signU32;
  logic [39:0] bcdU32;
  logic [3:0]  countU32;

  logic        selReady, selValid, selSign;
  logic [63:0] selBcd;
  logic [3:0]  selCount;

  int errorCount = 0;
  int checkCount = 0;

  double_dabble_seq #(.BIN_WIDTH(16), .SIGNED(0)) dutU16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 0), .in_ready(inReadyU16),
    .in_data(inData[15:0]), .out_valid(outValidU16), .out_ready(outReady),
    .bcd_out(bcdU16), .sign_out(signU16), .digit_count(countU16));

  double_dabble_seq #(.BIN_WIDTH(16), .SIGNED(1)) dutS16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 1), .in_ready(inReadyS16),
    .in_data(inData[15:0]), .out_valid(outValidS16), .out_ready(outReady),
    .bcd_out(bcdS16), .sign_out(signS16), .digit_count(countS16));

  double_dabble_seq #(.BIN_WIDTH(10), .SIGNED(0)) dutU10 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 2), .in_ready(inReadyU10),
    .in_data(inData[9:0]), .out_valid(outValidU10), .out_ready(outReady),
    .bcd_out(bcdU10), .sign_out(signU10), .digit_count(countU10));

  double_dabble_seq #(.BIN_WIDTH(32), .SIGNED(0)) dutU32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 3), .in_ready(inReadyU32),
    .in_data(inData), .out_valid(outValidU32), .out_ready(outReady),
    .bcd_out(bcdU32), .sign_out(signU32), .digit_count(countU32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    selReady = inReadyU16; selValid = outValidU16; selSign = signU16;
    selBcd = 64'(bcdU16); selCount = 4'(countU16);
    case (sel)
      1: begin
        selReady = inReadyS16; selValid = outValidS16; selSign = signS16;
        selBcd = 64'(bcdS16); selCount = 4'(countS16);
      end
      2: begin
        selReady = inReadyU10; selValid = outValidU10; selSign = signU10;
        selBcd = 64'(bcdU10); selCount = 4'(countU10);
      end
      3: begin
        selReady = inReadyU32; selValid = outValidU32; selSign = signU32;
        selBcd = 64'(bcdU32); selCount = countU32;
      end
      default: ;
    endcase
  end

  function automatic logic [63:0] refBcd(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int refCount(input logic [63:0] v);
    int n;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic int widthOf(input int s);
    case (s)
      0, 1:    return 16;
      2:       return 10;
      default: return 32;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Starts from IDLE at #1 after an edge; returns one result with out_ready held high.
  task automatic applyStimulus(input int s, input logic [31:0] value, output logic [63:0] bcd,
                               output logic sign, output int count, output int cycles);
    sel      = s;
    outReady = 1'b1;
    inData   = value;
    inValid  = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    cycles  = 0;
    while (!selValid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    bcd   = selBcd;
    sign  = selSign;
    count = int'(selCount);
    @(posedge clk); #1;
  endtask

  vec_t        vecs[14];
  logic [63:0] gotBcd;
  logic        gotSign;
  int          gotCount;
  int          gotCycles;

  initial begin
    vecs[0]  = '{0, 32'h0000_FFFF, 64'h65535,      1'b0, 5};
    vecs[1]  = '{0, 32'h0000_0000, 64'h00000,      1'b0, 1};
    vecs[2]  = '{0, 32'h0000_04D2, 64'h01234,      1'b0, 4};
    vecs[3]  = '{0, 32'h0000_000A, 64'h00010,      1'b0, 2};
    vecs[4]  = '{1, 32'h0000_8000, 64'h32768,      1'b1, 5};
    vecs[5]  = '{1, 32'h0000_FFFF, 64'h00001,      1'b1, 1};
    vecs[6]  = '{1, 32'h0000_7FFF, 64'h32767,      1'b0, 5};
    vecs[7]  = '{1, 32'h0000_0000, 64'h00000,      1'b0, 1};
    vecs[8]  = '{1, 32'h0000_FF9C, 64'h00100,      1'b1, 3};
    vecs[9]  = '{2, 32'h0000_03FF, 64'h1023,       1'b0, 4};
    vecs[10] = '{2, 32'h0000_0000, 64'h0000,       1'b0, 1};
    vecs[11] = '{3, 32'hFFFF_FFFF, 64'h4294967295, 1'b0, 10};
    vecs[12] = '{3, 32'h3B9A_CA00, 64'h1000000000, 1'b0, 10};
    vecs[13] = '{3, 32'h05F5_E0FF, 64'h0099999999, 1'b0, 8};

    rst_n    = 1'b0;
    sel      = 0;
    inValid  = 1'b0;
    outReady = 1'b1;
    inData   = '0;

    #12;
    checkOutput("reset out_valid", outValidU16, 0);
    checkOutput("reset bcd_out", bcdU16, 0);
    checkOutput("reset sign_out", signS16, 0);
    checkOutput("reset digit_count", countU16, 0);
    checkOutput("reset in_ready", inReadyU16, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].data, gotBcd, gotSign, gotCount, gotCycles);
      checkOutput($sformatf("vec%0d latency", i), gotCycles, widthOf(vecs[i].sel));
      checkOutput($sformatf("vec%0d bcd_out", i), gotBcd, vecs[i].bcd);
      checkOutput($sformatf("vec%0d sign_out", i), gotSign, vecs[i].sign);
      checkOutput($sformatf("vec%0d digit_count", i), gotCount, vecs[i].count);
    end

    // Backpressure: result must stay frozen while out_ready is low.
    begin
      int waitCycles;
      sel      = 0;
      outReady = 1'b0;
      inData   = 32'd1234;
      inValid  = 1'b1;
      @(posedge clk); #1;
      inValid    = 1'b0;
      waitCycles = 0;
      while (!selValid && waitCycles < 200) begin
        @(posedge clk); #1;
        waitCycles++;
      end
      checkOutput("bp latency", waitCycles, 16);
      for (int i = 0; i < 10; i++) begin
        checkOutput("bp out_valid", selValid, 1);
        checkOutput("bp bcd_out", selBcd, 64'h01234);
        checkOutput("bp digit_count", selCount, 4);
        checkOutput("bp in_ready", selReady, 0);
        @(posedge clk); #1;
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp release out_valid", selValid, 0);
      checkOutput("bp release in_ready", selReady, 1);
    end

    // Busy rejection: a fresh value every cycle, only ready cycles convert.
    begin
      int          acceptK[$];
      logic [31:0] acceptV[$];
      int          results;
      results  = 0;
      sel      = 0;
      outReady = 1'b1;
      inValid  = 1'b1;
      for (int k = 0; k < 54; k++) begin
        inData = 32'(200 + 37 * k);
        if (selValid) begin
          results++;
          if (acceptV.size() > 0) checkOutput("busy bcd_out", selBcd, refBcd(64'(acceptV.pop_front())));
        end
        if (selReady) begin
          acceptK.push_back(k);
          acceptV.push_back(inData);
        end
        @(posedge clk); #1;
      end
      inValid = 1'b0;
      checkOutput("busy accepted", acceptK.size(), 3);
      checkOutput("busy results", results, 3);
      if (acceptK.size() >= 3) begin
        checkOutput("busy first accept", acceptK[0], 0);
        checkOutput("busy period a", acceptK[1] - acceptK[0], 18);
        checkOutput("busy period b", acceptK[2] - acceptK[1], 18);
      end
    end

    // Reset during SHIFT: everything clears at once and the operand is lost.
    begin
      logic seen;
      sel      = 0;
      outReady = 1'b1;
      inData   = 32'd4321;
      inValid  = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (7) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("abort out_valid", selValid, 0);
      checkOutput("abort bcd_out", selBcd, 0);
      checkOutput("abort sign_out", selSign, 0);
      checkOutput("abort digit_count", selCount, 0);
      checkOutput("abort in_ready", selReady, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (30) begin
        @(posedge clk); #1;
        if (selValid) seen = 1'b1;
      end
      checkOutput("abort no out_valid", seen, 0);
      applyStimulus(0, 32'd999, gotBcd, gotSign, gotCount, gotCycles);
      checkOutput("after abort bcd_out", gotBcd, 64'h00999);
      checkOutput("after abort digit_count", gotCount, 3);
    end

    for (int v = 0; v < 1024; v++) begin
      applyStimulus(2, 32'(v), gotBcd, gotSign, gotCount, gotCycles);
      checkOutput("u10 bcd_out", gotBcd, refBcd(64'(v)));
      checkOutput("u10 digit_count", gotCount, refCount(64'(v)));
    end

    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      r = $urandom();
      applyStimulus(3, r, gotBcd, gotSign, gotCount, gotCycles);
      checkOutput("u32 bcd_out", gotBcd, refBcd(64'(r)));
      checkOutput("u32 digit_count", gotCount, refCount(64'(r)));
      checkOutput("u32 sign_out", gotSign, 0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
